// File: rtl/data_ram_be_pkg.sv
// data_ram_be_pkg: shared defaults, reset/zero constants and INIT/READY encodings.
package data_ram_be_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF = 4096;
  localparam int ADDR_W_DEF = 32;
  localparam logic RST_ENABLE = 1'b0;
  localparam logic [DATA_W_DEF-1:0] ZERO_WORD = '0;
  typedef enum logic {INIT = 1'b0, READY = 1'b1} state_t;
endpackage

// File: rtl/data_ram_be_init_ctrl.sv
// ram_init_ctrl: post-reset clear sequencer, zeroes one word per cycle then enters READY.
module ram_init_ctrl
  import data_ram_be_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             arst_n,
  output logic             clr_we,
  output logic [IDX_W-1:0] clr_idx,
  output logic             init_done
);
  state_t state, state_nxt;
  logic [IDX_W-1:0] cnt;
  always_ff @(posedge clk or negedge arst_n) begin
    if (arst_n == RST_ENABLE) begin
      state <= INIT;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= clr_we ? cnt + 1'b1 : cnt;
    end
  end
  always_comb begin
    state_nxt = (state == INIT && cnt == IDX_W'(DEPTH - 1)) ? READY : state;
    clr_we = state == INIT;
    clr_idx = cnt;
    init_done = state == READY;
  end
endmodule

// File: rtl/data_ram_be.sv
// data_ram_be: byte-strobed MEM-stage data RAM with registered read and fault checks.
// Define DRAM_BYPASS_EN for write-first forwarding on a same-cycle read/write of one word.
module data_ram_be
  import data_ram_be_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  localparam int BE_W = DATA_W / 8
) (
  input  logic              clk_100MHz,
  input  logic              arst_n,
  input  logic              r_req_i,
  input  logic [ADDR_W-1:0] r_addr_i,
  output logic              r_valid_o,
  output logic [DATA_W-1:0] r_data_o,
  output logic              r_err_o,
  input  logic              w_ena_i,
  input  logic [ADDR_W-1:0] w_addr_i,
  input  logic [BE_W-1:0]   w_be_i,
  input  logic [DATA_W-1:0] w_data_i,
  output logic              w_err_o,
  output logic              init_done_o
);
  localparam int OFF_W = $clog2(BE_W);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] w_word, r_word;
  logic [IDX_W-1:0] r_idx, w_idx, clr_idx;
  logic r_fault, w_fault, clr_we, r_do, w_do;
  function automatic logic fault(input logic [ADDR_W-1:0] a);
    return (|(a & OFF_MASK)) || (|(a >> (OFF_W + IDX_W)));
  endfunction
  ram_init_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_init (
    .clk(clk_100MHz),
    .arst_n(arst_n),
    .clr_we(clr_we),
    .clr_idx(clr_idx),
    .init_done(init_done_o)
  );
  assign r_fault = fault(r_addr_i);
  assign w_fault = fault(w_addr_i);
  assign r_idx = r_addr_i[OFF_W +: IDX_W];
  assign w_idx = w_addr_i[OFF_W +: IDX_W];
  assign r_do = init_done_o && r_req_i;
  assign w_do = init_done_o && w_ena_i && !w_fault;
  always_comb begin
    w_word = mem[w_idx];
    for (int k = 0; k < BE_W; k++)
      if (w_be_i[k]) w_word[8*k +: 8] = w_data_i[8*k +: 8];
  end
`ifdef DRAM_BYPASS_EN
  assign r_word = (w_do && w_idx == r_idx) ? w_word : mem[r_idx];
`else
  assign r_word = mem[r_idx];
`endif
  // Storage has no reset; the INIT pass clears it instead.
  always_ff @(posedge clk_100MHz) begin
    if (clr_we) mem[clr_idx] <= DATA_W'(ZERO_WORD);
    else if (w_do) mem[w_idx] <= w_word;
  end
  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (arst_n == RST_ENABLE) begin
      r_valid_o <= 1'b0;
      r_data_o <= '0;
      r_err_o <= 1'b0;
      w_err_o <= 1'b0;
    end else begin
      r_valid_o <= r_do;
      r_data_o <= (r_do && !r_fault) ? r_word : '0;
      r_err_o <= r_do && r_fault;
      w_err_o <= init_done_o && w_ena_i && w_fault;
    end
  end
endmodule

// File: tb/tb_data_ram_be.sv
// tb_data_ram_be: directed self-checking bench for data_ram_be (DEPTH reduced to 16).
module tb_data_ram_be;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic r_req = 1'b0, w_ena = 1'b0;
  logic [31:0] r_addr = '0, w_addr = '0, w_data = '0, r_data;
  logic [3:0] w_be = '0;
  logic r_valid, r_err, w_err, init_done;
  int checks = 0, errors = 0;
  logic bad;

  data_ram_be #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk_100MHz(clk), .arst_n(arst_n),
    .r_req_i(r_req), .r_addr_i(r_addr), .r_valid_o(r_valid), .r_data_o(r_data), .r_err_o(r_err),
    .w_ena_i(w_ena), .w_addr_i(w_addr), .w_be_i(w_be), .w_data_i(w_data), .w_err_o(w_err),
    .init_done_o(init_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 64'(r_valid), 64'd0);
    check({tag, "_data"}, 64'(r_data), 64'd0);
    check({tag, "_rerr"}, 64'(r_err), 64'd0);
    check({tag, "_werr"}, 64'(w_err), 64'd0);
    check({tag, "_done"}, 64'(init_done), 64'd0);
  endtask

  task automatic wait_init(input string tag);
    for (int i = 1; i < DEPTH; i++) tick();
    check({tag, "_done_early"}, 64'(init_done), 64'd0);
    tick();
    check({tag, "_done_edge"}, 64'(init_done), 64'd1);
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp, input logic exp_err);
    r_req = 1'b1;
    r_addr = a;
    tick();
    r_req = 1'b0;
    check({tag, "_valid"}, 64'(r_valid), 64'd1);
    check({tag, "_data"}, 64'(r_data), 64'(exp));
    check({tag, "_err"}, 64'(r_err), 64'(exp_err));
  endtask

  task automatic wr(input string tag, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d, input logic exp_err);
    w_ena = 1'b1;
    w_addr = a;
    w_be = be;
    w_data = d;
    tick();
    w_ena = 1'b0;
    check({tag, "_werr"}, 64'(w_err), 64'(exp_err));
  endtask

  initial begin
    tick();
    tick();
    check_idle("reset");
    // Requests held throughout the first INIT pass must be ignored.
    arst_n = 1'b1;
    r_req = 1'b1;
    r_addr = 32'h4;
    w_ena = 1'b1;
    w_addr = 32'h4;
    w_be = 4'hF;
    w_data = 32'hFFFF_FFFF;
    bad = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      tick();
      bad |= r_valid | w_err | init_done;
      if (i == DEPTH / 2) w_addr = 32'h13;
    end
    check("init_quiet", 64'(bad), 64'd0);
    r_req = 1'b0;
    w_ena = 1'b0;
    tick();
    check("init_done_edge", 64'(init_done), 64'd1);
    check("init_no_valid", 64'(r_valid), 64'd0);
    // Back-to-back reads of every word.
    r_req = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      r_addr = 32'(i * 4);
      tick();
      check("zero_valid", 64'(r_valid), 64'd1);
      check("zero_data", 64'(r_data), 64'd0);
      check("zero_err", 64'(r_err), 64'd0);
    end
    r_req = 1'b0;
    tick();
    check("valid_drop", 64'(r_valid), 64'd0);
    check("data_drop", 64'(r_data), 64'd0);
    // Byte-lane merge.
    wr("w_full", 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b0);
    wr("w_lane0", 32'h10, 4'h1, 32'h0000_00AA, 1'b0);
    rd("r_merge", 32'h10, 32'hDEAD_BEAA, 1'b0);
    wr("w_be0", 32'h10, 4'h0, 32'h1234_5678, 1'b0);
    rd("r_be0", 32'h10, 32'hDEAD_BEAA, 1'b0);
    // Faulted writes and reads.
    wr("w_mis", 32'h13, 4'hF, 32'h5555_5555, 1'b1);
    check("werr_pulse", 64'(w_err), 64'd1);
    tick();
    check("werr_clear", 64'(w_err), 64'd0);
    wr("w_oor", 32'(DEPTH * 4), 4'hF, 32'h6666_6666, 1'b1);
    rd("r_after_mis", 32'h10, 32'hDEAD_BEAA, 1'b0);
    rd("r_after_oor", 32'h0, 32'h0, 1'b0);
    rd("r_mis", 32'h13, 32'h0, 1'b1);
    rd("r_oor", 32'(DEPTH * 4), 32'h0, 1'b1);
    // Same-cycle read and write of one word.
    wr("w_20", 32'h20, 4'hF, 32'hAABB_CCDD, 1'b0);
    w_ena = 1'b1;
    w_addr = 32'h20;
    w_be = 4'h3;
    w_data = 32'h1122_3344;
`ifdef DRAM_BYPASS_EN
    rd("r_same", 32'h20, 32'hAABB_3344, 1'b0);
`else
    rd("r_same", 32'h20, 32'hAABB_CCDD, 1'b0);
`endif
    w_ena = 1'b0;
    rd("r_next", 32'h20, 32'hAABB_3344, 1'b0);
    // A faulted write to the same word index never forwards.
    w_ena = 1'b1;
    w_addr = 32'h23;
    w_be = 4'hF;
    w_data = 32'h0;
    rd("r_nofwd", 32'h20, 32'hAABB_3344, 1'b0);
    w_ena = 1'b0;
    check("nofwd_werr", 64'(w_err), 64'd1);
    // Reset while a valid is showing and another read is in flight.
    r_req = 1'b1;
    r_addr = 32'h10;
    tick();
    check("pre_rst_valid", 64'(r_valid), 64'd1);
    check("pre_rst_data", 64'(r_data), 64'(32'hDEAD_BEAA));
    #2 arst_n = 1'b0;
    #1 check_idle("async_rst");
    tick();
    check("no_stale_valid", 64'(r_valid), 64'd0);
    r_req = 1'b0;
    arst_n = 1'b1;
    // Reset again mid-INIT; the clear pass must restart from zero.
    for (int i = 0; i < 5; i++) tick();
    check("mid_init_done", 64'(init_done), 64'd0);
    #2 arst_n = 1'b0;
    #1 check_idle("mid_init_rst");
    tick();
    arst_n = 1'b1;
    wait_init("reinit");
    rd("r_recleared_10", 32'h10, 32'h0, 1'b0);
    rd("r_recleared_20", 32'h20, 32'h0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/data_ram_be.md
# data_ram_be

Parametrised single-port-write / single-port-read data memory for the pipeline's MEM stage, succeeding the flat word RAM. It adds byte-lane write strobes, a registered one-cycle read with a valid pulse, alignment and range checking, and a post-reset clear sequencer in place of an all-at-once array reset. It sits between the MEM-stage load/store unit and the `MEM_WB` register.

## Interface
Parameters:
- DATA_W, 32, data word width in bits; must be a multiple of 8.
- DEPTH, 4096, number of words; must be a power of two.
- ADDR_W, 32, byte-address width.
- BE_W, DATA_W/8, number of byte lanes; derived, not overridden.

Ports:
- clk_100MHz  in  1  sole clock, rising edge.
- arst_n  in  1  asynchronous, active-low reset.
- r_req_i  in  1  read request.
- r_addr_i  in  ADDR_W  read byte address.
- r_valid_o  out  1  read data valid, one-cycle pulse.
- r_data_o  out  DATA_W  read data.
- r_err_o  out  1  read fault, qualified by r_valid_o.
- w_ena_i  in  1  write request.
- w_addr_i  in  ADDR_W  write byte address.
- w_be_i  in  BE_W  byte-lane write strobes; bit k covers w_data_i[8k+7:8k].
- w_data_i  in  DATA_W  write data.
- w_err_o  out  1  registered write fault pulse.
- init_done_o  out  1  high once the clear sequence has completed.

## Operation
- The address splits as OFF = log2(BE_W) low bits, then IDX = log2(DEPTH) word-index bits.
- Fault condition: a nonzero low OFF bits (misaligned), or any address bit above OFF+IDX set (out of range).
- The FSM has two states, INIT and READY.
- INIT:
  - Entered on reset. A word counter starts at 0.
  - Writes zero to word[cnt] each cycle and increments cnt.
  - After word DEPTH-1 is written, moves to READY and sets init_done_o.
  - r_req_i and w_ena_i are ignored; no valid or error pulses are produced.
- READY:
  - Write: when w_ena_i is high and the address is not faulted, byte lane k of the word is updated iff w_be_i[k]. w_be_i == 0 is a legal no-op.
  - Faulted write: memory is unchanged and w_err_o pulses.
  - Read: r_req_i samples the address. The next cycle gives r_valid_o=1 and r_data_o=word.
  - Faulted read: r_data_o=0 and r_err_o=1.
- r_data_o and r_err_o are 0 whenever r_valid_o is 0.
- Reset asserted mid-operation:
  - All outputs clear immediately and the FSM returns to INIT with cnt=0.
  - Any in-flight read is dropped.
  - Contents are re-cleared by the new INIT pass.

## Timing
- Reset values: r_valid_o=0, r_data_o=0, r_err_o=0, w_err_o=0, init_done_o=0.
- INIT lasts exactly DEPTH cycles after arst_n deasserts. init_done_o rises on edge DEPTH; the first request is accepted in that cycle.
- Read latency is 1 cycle. Back-to-back reads give one valid pulse per cycle.
- A write at edge N is visible to a read requested in cycle N+1.
- Same-cycle read and write to the same word: behaviour depends on DRAM_BYPASS_EN (see Configuration).
- w_err_o is asserted in the cycle after the faulted w_ena_i.

## Configuration
- DRAM_BYPASS_EN defined: a same-cycle read of the word being written returns the merged value. Lanes with w_be_i set come from w_data_i; the other lanes come from the stored word. This is write-first behaviour.
- DRAM_BYPASS_EN undefined: the same case returns the pre-write contents (read-first), and the new data is visible from the next read.
- A faulted write never forwards, in either configuration.

## Structure
- Shared define header holds:
  - default DATA_W, DEPTH and ADDR_W values;
  - the RST_ENABLE and ZERO_WORD constants;
  - the INIT/READY state encodings.
- Sub-module ram_init_ctrl owns the INIT/READY FSM and the clear counter. It outputs clr_we, clr_idx and init_done.
- The top level owns the storage array, the byte merge, the fault decode and the bypass mux.

## Test plan
- Reset, hold requests for DEPTH cycles -> init_done_o rises exactly at edge DEPTH; reading every word returns 0x00000000 with r_err_o=0.
- Write 0xDEADBEEF to 0x10 with w_be_i=4'b1111, then write 0x000000AA with w_be_i=4'b0001 -> read of 0x10 returns 0xDEADBEAA one cycle after r_req_i.
- Write to 0x13 (misaligned) and to DEPTH*4 (out of range) -> w_err_o pulses each time; the target words are unchanged. Reads of the same addresses return r_err_o=1 and r_data_o=0.
- Same-cycle write of 0x11223344 (w_be_i=4'b0011) and read of 0x20 holding 0xAABBCCDD -> 0xAABB3344 with DRAM_BYPASS_EN, 0xAABBCCDD without; the following read returns 0xAABB3344 in both.
- Assert arst_n low mid-INIT and also between a read request and its valid -> outputs go to 0 immediately, no stale r_valid_o appears, and INIT restarts for a full DEPTH cycles.
- Requests issued during INIT -> no r_valid_o or w_err_o pulses, and memory still reads all zero after init_done_o.
